// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the MEM-stage load/store bus sequencer.
//   - access size encodings (SZ_BYTE / SZ_HALF / SZ_WORD)
//   - sequencer state enum
//   - store_lanes(): replicates right-aligned store data onto every byte lane
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    DONE,
    DRAIN
  } lsu_state_e;

  // The bus slave picks the lanes from addr/size, so the data is simply
  // replicated to every lane it might use.
  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] lanes;
    case (size)
      SZ_BYTE: lanes = {4{wdata[7:0]}};
      SZ_HALF: lanes = {2{wdata[15:0]}};
      default: lanes = wdata;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: extracts the addressed byte/half from a word-aligned read
// word and sign- or zero-extends it to 32 bits. Purely combinational; also
// used by the WB forwarding path.
//   rdata       in  32  word-aligned read data
//   addr_lo     in  2   address bits [1:0] of the access
//   size        in  2   SZ_BYTE / SZ_HALF / SZ_WORD
//   is_unsigned in  1   zero-extend instead of sign-extend
//   result      out 32  extended load value
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    case (size)
      SZ_BYTE: result = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
      SZ_HALF: result = {{16{~is_unsigned & half_sel[15]}}, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_bus_ctrl.sv
// lsu_bus_ctrl: MEM-stage load/store sequencer for a request/addr_ok/data_ok
// bus. Checks alignment, issues one transaction at a time, holds the stage
// until the response arrives, and drains responses orphaned by a flush.
//   clk, rst                       clock, async active-high reset
//   ms_valid/ms_mem_en/ms_mem_wr   MEM slot valid, memory op, store
//   ms_mem_size/ms_mem_unsigned    access size, zero-extend load
//   ms_addr/ms_wdata               effective address, store source data
//   ws_allowin, flush              WB accepts result, pipeline flush
//   ms_ready_go/ms_rdata           stage may advance, extended load result
//   ms_adel/ms_ades/ms_badvaddr    address-error exceptions and bad address
//   data_*                         bus request side and response side
module lsu_bus_ctrl
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ms_valid,
  input  logic        ms_mem_en,
  input  logic        ms_mem_wr,
  input  logic [1:0]  ms_mem_size,
  input  logic        ms_mem_unsigned,
  input  logic [31:0] ms_addr,
  input  logic [31:0] ms_wdata,
  input  logic        ws_allowin,
  input  logic        flush,
  output logic        ms_ready_go,
  output logic [31:0] ms_rdata,
  output logic        ms_adel,
  output logic        ms_ades,
  output logic [31:0] ms_badvaddr,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  lsu_state_e  state_q, state_d;
  logic        pend_q, pend_d;
  logic [31:0] result_q, result_d;
  logic [31:0] addr_q, wdata_q;
  logic [1:0]  size_q;
  logic        wr_q, uns_q;
  logic        access, misalign, accept;
  logic [31:0] load_result;

  assign access   = ms_valid & ms_mem_en & (ms_mem_size != 2'd3);
  assign misalign = ((ms_mem_size == SZ_HALF) & ms_addr[0]) |
                    ((ms_mem_size == SZ_WORD) & (ms_addr[1:0] != 2'd0));
  assign accept   = (state_q == IDLE) & access & ~misalign & ~flush;

  assign ms_adel     = access & misalign & ~ms_mem_wr;
  assign ms_ades     = access & misalign & ms_mem_wr;
  assign ms_badvaddr = ms_addr;

  // Bus fields come from registers captured at accept, so they stay stable
  // through ADDR even if a flush lets the pipeline move new values in.
  assign data_req   = (state_q == ADDR);
  assign data_wr    = wr_q;
  assign data_size  = size_q;
  assign data_addr  = addr_q;
  assign data_wdata = wdata_q;
  assign ms_rdata   = result_q;

  lsu_load_align u_load_align (
    .rdata       (data_rdata),
    .addr_lo     (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .result      (load_result)
  );

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    result_d    = result_q;
    ms_ready_go = 1'b0;
    case (state_q)
      IDLE: begin
        // Non-memory slots and excepting accesses pass straight through.
        ms_ready_go = ~access | misalign;
        if (accept) state_d = ADDR;
      end
      ADDR: begin
        if (flush) pend_d = 1'b1;
        if (data_addr_ok) begin
          state_d = (pend_q | flush) ? DRAIN : DATA;
          pend_d  = 1'b0;
        end
      end
      DATA: begin
        if (flush) begin
          state_d = data_data_ok ? IDLE : DRAIN;
        end else if (data_data_ok) begin
          // Store acks carry no data; keep the last load result.
          if (!wr_q) result_d = load_result;
          state_d = DONE;
        end
      end
      DONE: begin
        ms_ready_go = 1'b1;
        if (ws_allowin | flush) state_d = IDLE;
      end
      DRAIN: begin
        if (data_data_ok) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      pend_q   <= 1'b0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      result_q <= result_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      size_q  <= SZ_BYTE;
      wr_q    <= 1'b0;
      uns_q   <= 1'b0;
    end else if (accept) begin
      addr_q  <= ms_addr;
      wdata_q <= store_lanes(ms_mem_size, ms_wdata);
      size_q  <= ms_mem_size;
      wr_q    <= ms_mem_wr;
      uns_q   <= ms_mem_unsigned;
    end
  end

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Scoreboard bench for lsu_bus_ctrl: stimulus pushes the expected MEM result
// of each slot; a monitor pops it whenever the stage retires (valid, ready_go,
// allowin). Bus-side field checks are made inline by the stimulus.
module tb_lsu_bus_ctrl;

  logic        clk, rst;
  logic        ms_valid, ms_mem_en, ms_mem_wr, ms_mem_unsigned;
  logic [1:0]  ms_mem_size;
  logic [31:0] ms_addr, ms_wdata;
  logic        ws_allowin, flush;
  logic        ms_ready_go, ms_adel, ms_ades;
  logic [31:0] ms_rdata, ms_badvaddr;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;

  lsu_bus_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .ms_valid        (ms_valid),
    .ms_mem_en       (ms_mem_en),
    .ms_mem_wr       (ms_mem_wr),
    .ms_mem_size     (ms_mem_size),
    .ms_mem_unsigned (ms_mem_unsigned),
    .ms_addr         (ms_addr),
    .ms_wdata        (ms_wdata),
    .ws_allowin      (ws_allowin),
    .flush           (flush),
    .ms_ready_go     (ms_ready_go),
    .ms_rdata        (ms_rdata),
    .ms_adel         (ms_adel),
    .ms_ades         (ms_ades),
    .ms_badvaddr     (ms_badvaddr),
    .data_req        (data_req),
    .data_wr         (data_wr),
    .data_size       (data_size),
    .data_addr       (data_addr),
    .data_wdata      (data_wdata),
    .data_addr_ok    (data_addr_ok),
    .data_data_ok    (data_data_ok),
    .data_rdata      (data_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        chk_rdata;
    logic [31:0] rdata;
    logic        adel;
    logic        ades;
    logic [31:0] badv;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        e;
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] last_result = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare on every retirement of the MEM slot.
  always @(negedge clk) begin
    if (!rst && ms_valid && ms_ready_go && ws_allowin && !flush) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_retire: got addr %08h expected no retirement", ms_addr);
      end else begin
        e = sb_q.pop_front();
        check("ms_adel", 32'(ms_adel), 32'(e.adel));
        check("ms_ades", 32'(ms_ades), 32'(e.ades));
        check("ms_badvaddr", ms_badvaddr, e.badv);
        if (e.chk_rdata) check("ms_rdata", ms_rdata, e.rdata);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
    ms_valid = 1'b1; ms_mem_en = 1'b1; ms_mem_wr = wr; ms_mem_size = sz;
    ms_mem_unsigned = uns; ms_addr = addr; ms_wdata = wdata;
  endtask

  task automatic retire_slot();
    ms_valid = 1'b0; ms_mem_en = 1'b0; ms_addr = 32'h0000_0FFC; ms_wdata = 32'h0;
  endtask

  // Wait in DONE (optionally with a WB stall), then let the slot retire.
  task automatic finish_slot(input int stall);
    bit got = 1'b0;
    for (int i = 0; i < stall; i++) begin
      ws_allowin = 1'b0;
      @(negedge clk);
      check("stall_ready_go", 32'(ms_ready_go), 32'd1);
      check("stall_rdata_held", ms_rdata, last_result);
      step();
    end
    ws_allowin = 1'b1;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (ms_ready_go) got = 1'b1;
      else step();
    end
    if (!got) begin
      n_vec++;
      n_err++;
      $display("FAIL done_timeout: got no ms_ready_go expected it within 8 cycles");
    end
    step();
    retire_slot();
  endtask

  task automatic do_access(input logic wr, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_wdata, input int aw,
                           input logic [31:0] rdata, input logic [31:0] exp_rdata,
                           input int stall);
    sb_q.push_back('{chk_rdata: !wr, rdata: exp_rdata, adel: 1'b0, ades: 1'b0, badv: addr});
    present(wr, sz, uns, addr, wdata);
    step();
    for (int i = 0; i <= aw; i++) begin
      if (i == aw) data_addr_ok = 1'b1;
      @(negedge clk);
      check("addr_req", 32'(data_req), 32'd1);
      check("addr_data_addr", data_addr, addr);
      check("addr_data_size", 32'(data_size), 32'(sz));
      check("addr_data_wr", 32'(data_wr), 32'(wr));
      check("addr_data_wdata", data_wdata, exp_wdata);
      step();
    end
    data_addr_ok = 1'b0;
    data_data_ok = 1'b1;
    data_rdata   = rdata;
    @(negedge clk);
    check("data_req_low", 32'(data_req), 32'd0);
    check("data_ready_go_low", 32'(ms_ready_go), 32'd0);
    step();
    data_data_ok = 1'b0;
    data_rdata   = 32'h0;
    if (!wr) last_result = exp_rdata;
    finish_slot(stall);
  endtask

  task automatic do_exc(input logic wr, input logic [1:0] sz, input logic [31:0] addr,
                        input logic exp_adel, input logic exp_ades);
    sb_q.push_back('{chk_rdata: 1'b0, rdata: 32'h0, adel: exp_adel, ades: exp_ades, badv: addr});
    present(wr, sz, 1'b0, addr, 32'h5555_AAAA);
    @(negedge clk);
    check("exc_req", 32'(data_req), 32'd0);
    check("exc_ready_go", 32'(ms_ready_go), 32'd1);
    step();
    retire_slot();
    @(negedge clk);
    check("exc_stays_idle", 32'(data_req), 32'd0);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected completion before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ms_valid = 1'b0; ms_mem_en = 1'b0; ms_mem_wr = 1'b0; ms_mem_size = 2'd0;
    ms_mem_unsigned = 1'b0; ms_addr = 32'h0; ms_wdata = 32'h0; ws_allowin = 1'b1;
    flush = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;

    @(negedge clk);
    check("rst_req", 32'(data_req), 32'd0);
    check("rst_rdata", ms_rdata, 32'd0);
    check("rst_adel", 32'(ms_adel), 32'd0);
    check("rst_ades", 32'(ms_ades), 32'd0);
    check("rst_ready_go", 32'(ms_ready_go), 32'd1);
    step();
    rst = 1'b0;
    step();

    // Loads: width, lane and extension
    do_access(1'b0, 2'd2, 1'b0, 32'h8000_0004, 32'h0, 32'h0, 0, 32'h1234_5678, 32'h1234_5678, 0);
    do_access(1'b0, 2'd0, 1'b0, 32'h8000_0003, 32'h0, 32'h0, 1, 32'h80FF_FF00, 32'hFFFF_FF80, 0);
    do_access(1'b0, 2'd0, 1'b1, 32'h8000_0003, 32'h0, 32'h0, 0, 32'h80FF_FF00, 32'h0000_0080, 0);
    do_access(1'b0, 2'd1, 1'b0, 32'h8000_0002, 32'h0, 32'h0, 0, 32'h8001_7FFF, 32'hFFFF_8001, 0);
    do_access(1'b0, 2'd1, 1'b1, 32'h8000_0000, 32'h0, 32'h0, 2, 32'h0000_F00F, 32'h0000_F00F, 0);
    do_access(1'b0, 2'd0, 1'b0, 32'h8000_0001, 32'h0, 32'h0, 0, 32'h0000_7F00, 32'h0000_007F, 0);

    // Stores: lane replication, slow addr_ok, result untouched
    do_access(1'b1, 2'd1, 1'b0, 32'h8000_0002, 32'h0000_ABCD, 32'hABCD_ABCD, 0, 32'h0, 32'h0, 0);
    do_access(1'b1, 2'd0, 1'b0, 32'h8000_0001, 32'h1234_56EF, 32'hEFEF_EFEF, 1, 32'h0, 32'h0, 0);
    do_access(1'b1, 2'd2, 1'b0, 32'h8000_0008, 32'h1122_3344, 32'h1122_3344, 5, 32'h0, 32'h0, 0);
    @(negedge clk);
    check("store_keeps_result", ms_rdata, last_result);
    step();

    // WB stall in DONE
    do_access(1'b0, 2'd2, 1'b0, 32'h8000_000C, 32'h0, 32'h0, 0, 32'hA5A5_0F0F, 32'hA5A5_0F0F, 3);

    // Address errors and the illegal size
    do_exc(1'b0, 2'd2, 32'h8000_0002, 1'b1, 1'b0);
    do_exc(1'b1, 2'd1, 32'h8000_0001, 1'b0, 1'b1);
    do_exc(1'b0, 2'd1, 32'h8000_0003, 1'b1, 1'b0);
    do_exc(1'b1, 2'd2, 32'h8000_0006, 1'b0, 1'b1);
    do_exc(1'b0, 2'd3, 32'h8000_0003, 1'b0, 1'b0);

    // Flush in ADDR: req held until addr_ok, then drain
    present(1'b0, 2'd2, 1'b0, 32'h8000_0010, 32'h0);
    step();
    flush = 1'b1;
    retire_slot();
    @(negedge clk);
    check("flush_req_held", 32'(data_req), 32'd1);
    step();
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) data_addr_ok = 1'b1;
      @(negedge clk);
      check("flush_req_until_ok", 32'(data_req), 32'd1);
      check("flush_addr_stable", data_addr, 32'h8000_0010);
      step();
    end
    data_addr_ok = 1'b0;
    present(1'b0, 2'd2, 1'b0, 32'h8000_0020, 32'h0);
    @(negedge clk);
    check("drain_no_req", 32'(data_req), 32'd0);
    check("drain_stall", 32'(ms_ready_go), 32'd0);
    step();
    data_data_ok = 1'b1;
    data_rdata   = 32'hDEAD_BEEF;
    @(negedge clk);
    check("drain_stall_ok", 32'(ms_ready_go), 32'd0);
    step();
    data_data_ok = 1'b0;
    retire_slot();
    @(negedge clk);
    check("drain_back_idle", 32'(ms_ready_go), 32'd1);
    check("drain_result_kept", ms_rdata, last_result);
    step();
    do_access(1'b0, 2'd2, 1'b0, 32'h8000_0020, 32'h0, 32'h0, 0, 32'h0BAD_F00D, 32'h0BAD_F00D, 0);

    // Flush together with data_ok in DATA: discard and return to IDLE
    present(1'b0, 2'd2, 1'b0, 32'h8000_0030, 32'h0);
    step();
    data_addr_ok = 1'b1;
    @(negedge clk);
    step();
    data_addr_ok = 1'b0;
    flush = 1'b1;
    data_data_ok = 1'b1;
    data_rdata = 32'hCAFE_F00D;
    retire_slot();
    @(negedge clk);
    check("fd_req_low", 32'(data_req), 32'd0);
    step();
    flush = 1'b0;
    data_data_ok = 1'b0;
    @(negedge clk);
    check("fd_idle", 32'(ms_ready_go), 32'd1);
    check("fd_result_kept", ms_rdata, last_result);
    step();

    // Reset while in ADDR
    present(1'b0, 2'd2, 1'b0, 32'h8000_0040, 32'h0);
    step();
    rst = 1'b1;
    retire_slot();
    @(negedge clk);
    check("mid_rst_req", 32'(data_req), 32'd0);
    check("mid_rst_rdata", ms_rdata, 32'd0);
    step();
    rst = 1'b0;
    last_result = 32'd0;
    step();
    do_access(1'b0, 2'd1, 1'b0, 32'h8000_0046, 32'h0, 32'h0, 0, 32'h7FFF_0000, 32'h0000_7FFF, 0);

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
